// File: rtl/osc_freq_counter.sv
// osc_freq_counter: counts rising edges of an asynchronous oscillator
// over a programmable gate window and presents the result bytewise.
module osc_freq_counter #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16,
  parameter int GATE_BASE   = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       osc_in,
  input  logic [1:0] gate_sel,
  input  logic       cont,
  input  logic       start,
  input  logic       byte_sel,
  output logic [7:0] dout,
  output logic       busy,
  output logic       done,
  output logic       upd,
  output logic       ovf
);

  localparam int GW = GATE_BASE + 6;
  localparam logic [GW-1:0] G_ONE = GW'(1);
  localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_MAX = '1;
  localparam logic [CNT_W-1:0] C_NEAR = C_MAX - C_ONE;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GATE  = 2'd1,
    LATCH = 2'd2
  } state_t;

  state_t state;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   edge_q;
  logic                   start_q;
  logic                   rise;
  logic                   trig;
  logic [1:0]             gsel_q;
  logic [GW-1:0]          gcnt;
  logic [GW-1:0]          gate_last;
  logic [CNT_W-1:0]       ecnt;
  logic [CNT_W-1:0]       result;
  logic                   sat;
  logic [7:0]             hi_byte;

  // Synchronise osc_in, keep an edge history and register start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      edge_q  <= 1'b0;
      start_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], osc_in};
      edge_q  <= sync_q[SYNC_STAGES-1];
      start_q <= start;
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~edge_q;
  assign trig = cont | (start & ~start_q);

  // Last gate count index; the largest window wraps to all-ones
  always_comb begin
    gate_last = (G_ONE << (GATE_BASE + 2 * int'(gsel_q))) - G_ONE;
  end

  // Measurement FSM with gate/edge counters and result register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      gsel_q <= 2'd0;
      gcnt   <= '0;
      ecnt   <= '0;
      sat    <= 1'b0;
      result <= '0;
      done   <= 1'b0;
      ovf    <= 1'b0;
    end else if (!ena) begin
      state <= IDLE;
      gcnt  <= '0;
      ecnt  <= '0;
      sat   <= 1'b0;
      done  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (trig) begin
            state  <= GATE;
            gcnt   <= '0;
            ecnt   <= '0;
            sat    <= 1'b0;
            gsel_q <= gate_sel;
          end
        end
        GATE: begin
          gcnt <= gcnt + G_ONE;
          if (rise && ecnt != C_MAX) begin
            ecnt <= ecnt + C_ONE;
          end
          if (rise && ecnt >= C_NEAR) begin
            sat <= 1'b1;
          end
          if (gcnt == gate_last) begin
            state <= LATCH;
          end
        end
        LATCH: begin
          result <= ecnt;
          ovf    <= sat;
          done   <= 1'b1;
          gcnt   <= '0;
          ecnt   <= '0;
          sat    <= 1'b0;
          if (cont) begin
            state  <= GATE;
            gsel_q <= gate_sel;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  generate
    if (CNT_W > 8) begin : g_hi
      assign hi_byte = 8'(result[CNT_W-1:8]);
    end else begin : g_nohi
      assign hi_byte = 8'h00;
    end
  endgenerate

  assign dout = byte_sel ? hi_byte : result[7:0];
  assign busy = (state != IDLE);
  assign upd  = (state == LATCH) & ena;

endmodule

// File: tb/tb_osc_freq_counter.sv
// tb_osc_freq_counter: directed stimulus with a queued scoreboard
// checked by an independent monitor on every result update.
module tb_osc_freq_counter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       ena = 1'b0;
  logic       ena8 = 1'b0;
  logic       osc_in = 1'b0;
  logic [1:0] gate_sel = 2'd0;
  logic       cont = 1'b0;
  logic       start = 1'b0;
  logic       byte_sel = 1'b0;
  logic [7:0] dout, dout8;
  logic       busy, done, upd, ovf;
  logic       busy8, done8, upd8, ovf8;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int osc_per = 0;
  int last_upd[2];

  typedef struct {
    int lo;
    int hi;
    int ovf;
    int at;
    int gap;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  osc_freq_counter u_dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .osc_in(osc_in),
    .gate_sel(gate_sel), .cont(cont), .start(start),
    .byte_sel(byte_sel), .dout(dout), .busy(busy),
    .done(done), .upd(upd), .ovf(ovf)
  );

  osc_freq_counter #(.CNT_W(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .ena(ena8), .osc_in(osc_in),
    .gate_sel(gate_sel), .cont(cont), .start(start),
    .byte_sel(byte_sel), .dout(dout8), .busy(busy8),
    .done(done8), .upd(upd8), .ovf(ovf8)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    forever begin
      if (osc_per < 2) begin
        @(posedge clk);
      end else begin
        repeat (osc_per / 2) @(posedge clk);
        #3 osc_in = ~osc_in;
      end
    end
  end

  function automatic exp_t mk(int lo, int hi, int o, int at, int gap);
    exp_t e;
    e.lo = lo;
    e.hi = hi;
    e.ovf = o;
    e.at = at;
    e.gap = gap;
    return e;
  endfunction

  task automatic chk(input string name, input int act,
                     input int lo, input int hi);
    n_chk++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic mon(input int w);
    exp_t e;
    int lo8, hi8;
    n_chk++;
    if ((w == 0 && q0.size() == 0) || (w == 1 && q1.size() == 0)) begin
      n_fail++;
      $display("FAIL unexpected_upd dut%0d: upd at cycle %0d, want none",
               w, cyc);
      return;
    end
    e = (w == 0) ? q0.pop_front() : q1.pop_front();
    if (e.at >= 0) chk("upd_cycle", cyc, e.at, e.at);
    if (e.gap > 0) chk("upd_gap", cyc - last_upd[w], e.gap, e.gap);
    last_upd[w] = cyc;
    @(negedge clk);
    byte_sel = 1'b0;
    #1 lo8 = (w == 0) ? int'(dout) : int'(dout8);
    byte_sel = 1'b1;
    #1 hi8 = (w == 0) ? int'(dout) : int'(dout8);
    byte_sel = 1'b0;
    chk("result", hi8 * 256 + lo8, e.lo, e.hi);
    chk("ovf", (w == 0) ? int'(ovf) : int'(ovf8), e.ovf, e.ovf);
    chk("done", (w == 0) ? int'(done) : int'(done8), 1, 1);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (upd) mon(0);
      else if (upd8) mon(1);
    end
  end

  initial begin
    int t;
    int bad;
    #1 rst_n = 1'b0;
    tick(3);
    chk("rst_busy", int'(busy), 0, 0);
    chk("rst_done", int'(done), 0, 0);
    chk("rst_upd", int'(upd), 0, 0);
    chk("rst_ovf", int'(ovf), 0, 0);
    chk("rst_dout", int'(dout), 0, 0);
    chk("rst_dout8", int'(dout8), 0, 0);
    rst_n = 1'b1;
    ena = 1'b1;
    tick(2);

    osc_per = 10;
    gate_sel = 2'd0;
    tick(20);
    t = cyc;
    chk("idle_busy", int'(busy), 0, 0);
    q0.push_back(mk(25, 26, 0, t + 257, 0));
    pulse_start();
    chk("busy_rise", int'(busy), 1, 1);
    tick(256);
    chk("busy_latch", int'(busy), 1, 1);
    tick(1);
    chk("busy_fall", int'(busy), 0, 0);
    tick(5);

    t = cyc;
    pulse_start();
    tick(99);
    chk("gate_busy", int'(busy), 1, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", int'(busy), 0, 0);
    chk("arst_done", int'(done), 0, 0);
    chk("arst_upd", int'(upd), 0, 0);
    chk("arst_ovf", int'(ovf), 0, 0);
    chk("arst_dout", int'(dout), 0, 0);
    tick(2);
    rst_n = 1'b1;
    tick(300);
    chk("post_rst_busy", int'(busy), 0, 0);

    osc_per = 4;
    gate_sel = 2'd3;
    tick(10);
    t = cyc;
    q0.push_back(mk(4095, 4097, 0, t + 16385, 0));
    pulse_start();
    tick(16400);

    osc_per = 8;
    gate_sel = 2'd1;
    tick(10);
    t = cyc;
    q0.push_back(mk(127, 129, 0, t + 1025, 0));
    q0.push_back(mk(127, 129, 0, -1, 1025));
    q0.push_back(mk(127, 129, 0, -1, 1025));
    q0.push_back(mk(31, 33, 0, -1, 257));
    cont = 1'b1;
    bad = 0;
    for (int i = 1; i <= 3332; i++) begin
      tick(1);
      if (cyc == t + 2100) gate_sel = 2'd0;
      if (cyc == t + 3100) cont = 1'b0;
      if (!busy) bad++;
    end
    chk("busy_cont_gaps", bad, 0, 0);
    tick(1);
    chk("cont_stop_busy", int'(busy), 0, 0);

    osc_per = 10;
    gate_sel = 2'd0;
    tick(5);
    pulse_start();
    tick(49);
    chk("ena_gate_busy", int'(busy), 1, 1);
    ena = 1'b0;
    tick(1);
    chk("ena_busy", int'(busy), 0, 0);
    chk("ena_done", int'(done), 0, 0);
    chk("ena_ovf", int'(ovf), 0, 0);
    chk("ena_dout_lo", int'(dout), 31, 33);
    byte_sel = 1'b1;
    #1 chk("ena_dout_hi", int'(dout), 0, 0);
    byte_sel = 1'b0;
    ena = 1'b1;
    tick(2);
    t = cyc;
    q0.push_back(mk(25, 26, 0, t + 257, 0));
    pulse_start();
    tick(49);
    pulse_start();
    tick(49);
    pulse_start();
    tick(500);
    chk("no_requeue_busy", int'(busy), 0, 0);

    ena = 1'b0;
    ena8 = 1'b1;
    gate_sel = 2'd1;
    osc_per = 2;
    tick(10);
    t = cyc;
    q1.push_back(mk(255, 255, 1, t + 1025, 0));
    pulse_start();
    tick(1100);
    osc_per = 0;
    tick(20);
    t = cyc;
    q1.push_back(mk(0, 0, 0, t + 1025, 0));
    pulse_start();
    tick(1100);

    chk("sb_left_main", q0.size(), 0, 0);
    chk("sb_left_cnt8", q1.size(), 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/osc_freq_counter.md
Name: osc_freq_counter

Overview:
- Digital measurement stage directly downstream of the relaxation oscillator macro.
- Takes the oscillator's comparator output, which is asynchronous to clk, and counts its rising edges over a programmable gate window of clk cycles.
- Latches each count into a result register and presents it one byte at a time on the dedicated outputs.
- Gives on-chip frequency readout of the oscillator without an external counter.

Parameters:
- SYNC_STAGES, 2, flip-flop stages in the osc_in synchroniser (minimum 2).
- CNT_W, 16, width of the edge counter and result register (8..16).
- GATE_BASE, 8, base exponent; gate length = 2^(GATE_BASE + 2*gate_sel) clk cycles.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- ena  input  1  block enable; 0 forces idle.
- osc_in  input  1  oscillator square wave, asynchronous to clk.
- gate_sel  input  2  gate length select: 256/1024/4096/16384 cycles at GATE_BASE=8.
- cont  input  1  1 = free-running back-to-back measurements; 0 = single-shot.
- start  input  1  single-shot trigger; rising edge is detected internally.
- byte_sel  input  1  0 = result[7:0] on dout; 1 = result[CNT_W-1:8], zero-extended.
- dout  output  8  selected result byte.
- busy  output  1  high while in GATE or LATCH.
- done  output  1  sticky: at least one valid result held.
- upd  output  1  one-cycle pulse when result updates.
- ovf  output  1  last result saturated.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE.
  - Synchroniser, start_q, gate counter, edge counter and result are all 0.
  - dout=0, busy=0, done=0, upd=0, ovf=0.
  - Reset asserted mid-gate aborts immediately; nothing is latched.
- Edge detection:
  - osc_in passes through SYNC_STAGES flops, then one edge register.
  - rise = sync_out & ~edge_q.
  - An osc_in transition is counted SYNC_STAGES+1 cycles later.
  - Rises outside GATE are discarded.
  - Valid input frequency is below clk/2; this is not checked.
- Trigger: trig = cont | (start & ~start_q). start_q is a plain register of start.
- States:
  - IDLE: busy=0.
    - If ena & trig: go to GATE next cycle, clear gate and edge counters, and capture gate_sel into gsel_q.
  - GATE: busy=1.
    - Gate counter increments every cycle.
    - Each rise increments the edge counter, saturating at 2^CNT_W-1; once saturated, an internal sat flag is set.
    - The cycle with gate counter == G-1 still counts its rise; the next state is LATCH.
    - Exactly G cycles are spent in GATE.
  - LATCH: single cycle, busy=1.
    - result <= edge counter; ovf <= sat; done <= 1; upd = 1 for this cycle only.
    - A rise in this cycle is discarded (one-cycle dead time).
    - Next state: GATE with cleared counters and fresh gsel_q if cont=1 and ena=1; otherwise IDLE.
- Mid-operation input changes:
  - gate_sel changes during GATE are ignored until the next gate entry.
  - start edges during GATE or LATCH are ignored, not queued.
  - cont dropping during GATE completes the current measurement, then returns to IDLE.
- ena=0 (synchronous, any state):
  - Next state is IDLE; counters cleared.
  - done and ovf cleared; result retained.
  - No upd pulse.
  - ena=0 takes priority over the LATCH transition if both occur in the same cycle.
- dout is a combinational mux of the result register by byte_sel. A new result is visible on dout in the cycle after LATCH.
- Count width:
  - The edge counter is CNT_W bits and never wraps.
  - With CNT_W=16, no gate setting can saturate for valid inputs: at most 8192 rises in a 16384-cycle gate.

Test Plan:
- Reset during GATE (cycle 100 of 256) → busy, done, upd, ovf and dout all 0 asynchronously; state IDLE after release; no upd within 300 cycles.
- cont=0, gate_sel=0, osc_in period 10 clk, start pulse in cycle T → busy rises at T+1; upd at T+257; result 25 or 26; done=1; busy=0 at T+258.
- gate_sel=3, osc_in period 4 clk, single-shot → result 4096±1; byte_sel=0 gives 0x00 (or 0xFF/0x01), byte_sel=1 gives 0x10 (or 0x0F); ovf=0.
- cont=1, gate_sel=1, osc_in period 8 → upd pulses exactly 1025 cycles apart, each result 128±1, busy continuously 1; changing gate_sel to 0 mid-gate takes effect on the following window only.
- CNT_W=8, gate_sel=1, osc_in period 2 (512 rises) → result 255, ovf=1; next window with osc_in static → result 0, ovf=0.
- ena dropped at GATE cycle 50 → IDLE next cycle, busy=0, done=0, previous result still on dout; start pulses during GATE with ena=1 neither restart the gate nor queue a second measurement.
